writeback_stage_ext: RTL and testbench

//  Parametrised write-back stage for the RV32I 5-stage pipeline: N-way result select, load-data

---
 rtl/writeback_stage_ext.sv | 163 ++++++++++++++++
 tb/tb_writeback_stage_ext.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage_ext.sv
// writeback_stage_ext
//   Write-back stage of the RV32I pipeline. Selects one of NSRC result sources,
//   aligns and extends load data, and holds the stage in WAIT when load data is
//   late. Output write port is registered.
// Ports
//   clk, rst                  clock / async active-high reset
//   in_valid, in_ready        MEM/WB handshake (in_ready = state is IDLE)
//   ResultSrcW, src_bus       result select and flattened sources
//   funct3W, ByteOffW         load type and byte offset
//   RegWriteW, RdW            write enable and destination from decode
//   mem_rvalid, mem_rdata     data-memory read return
//   ResultW, RdOutW,
//   RegWriteOutW              registered register-file write port
//   stall                     ~in_ready, to the hazard unit
//   wb_err                    1-cycle pulse on a retired erroneous entry
//   wait_cnt                  saturating count of cycles spent in WAIT
//
// state | meaning
// IDLE  | accepting entries; loads with data present retire immediately
// WAIT  | load captured, waiting for mem_rvalid; upstream holds
module writeback_stage_ext #(
   parameter int XLEN     = 32,
   parameter int NSRC     = 4,
   parameter int LOAD_IDX = 1,
   localparam int SELW    = $clog2(NSRC)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SELW-1:0]      ResultSrcW,
   input  logic [NSRC*XLEN-1:0] src_bus,
   input  logic [2:0]           funct3W,
   input  logic [1:0]           ByteOffW,
   input  logic                 RegWriteW,
   input  logic [4:0]           RdW,
   input  logic                 mem_rvalid,
   input  logic [XLEN-1:0]      mem_rdata,
   output logic [XLEN-1:0]      ResultW,
   output logic [4:0]           RdOutW,
   output logic                 RegWriteOutW,
   output logic                 stall,
   output logic                 wb_err,
   output logic [31:0]          wait_cnt
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam logic [SELW-1:0] LOAD_SEL = LOAD_IDX[SELW-1:0];
   localparam logic [SELW:0]   NSRC_W   = NSRC[SELW:0];

   state_t          state, state_nxt;
   logic [2:0]      cap_f3;
   logic [1:0]      cap_off;
   logic [4:0]      cap_rd;
   logic            cap_we;

   logic            is_wait, is_load, use_load, sel_err, load_err, err;
   logic            retire, capture;
   logic [2:0]      f3;
   logic [1:0]      off;
   logic [4:0]      rd_sel;
   logic            we_sel;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [XLEN-1:0] src_val, load_val, res_val;

   assign in_ready = (state == S_IDLE);
   assign stall    = ~in_ready;

   always_comb begin
      is_wait = (state == S_WAIT);
      // In WAIT the live inputs are not trusted; use the captured load context.
      f3      = is_wait ? cap_f3  : funct3W;
      off     = is_wait ? cap_off : ByteOffW;
      rd_sel  = is_wait ? cap_rd  : RdW;
      we_sel  = is_wait ? cap_we  : RegWriteW;
      is_load = (ResultSrcW == LOAD_SEL);
      sel_err = ({1'b0, ResultSrcW} >= NSRC_W);

      src_val = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (ResultSrcW == k[SELW-1:0]) src_val = src_bus[k*XLEN +: XLEN];
      end

      byte_v   = mem_rdata[{off, 3'b000} +: 8];
      half_v   = off[1] ? mem_rdata[16 +: 16] : mem_rdata[0 +: 16];
      load_err = 1'b0;
      load_val = '0;
      case (f3)
         3'b000:  load_val = {{(XLEN-8){byte_v[7]}}, byte_v};
         3'b001:  begin load_val = {{(XLEN-16){half_v[15]}}, half_v}; load_err = off[0]; end
         3'b010:  begin load_val = mem_rdata; load_err = (off != 2'b00); end
         3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_v};
         3'b101:  begin load_val = {{(XLEN-16){1'b0}}, half_v}; load_err = off[0]; end
         default: load_err = 1'b1;
      endcase

      use_load = is_wait | is_load;
      err      = use_load ? load_err : sel_err;
      res_val  = err ? '0 : (use_load ? load_val : src_val);

      state_nxt = state;
      retire    = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (!is_load || mem_rvalid) begin
                  retire = 1'b1;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               retire    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_f3       <= '0;
         cap_off      <= '0;
         cap_rd       <= '0;
         cap_we       <= 1'b0;
         ResultW      <= '0;
         RdOutW       <= '0;
         RegWriteOutW <= 1'b0;
         wb_err       <= 1'b0;
         wait_cnt     <= '0;
      end else begin
         if (capture) begin
            cap_f3  <= funct3W;
            cap_off <= ByteOffW;
            cap_rd  <= RdW;
            cap_we  <= RegWriteW;
         end
         if (retire) begin
            ResultW      <= res_val;
            RdOutW       <= rd_sel;
            RegWriteOutW <= we_sel & (rd_sel != 5'd0) & ~err;
            wb_err       <= err;
         end else begin
            RegWriteOutW <= 1'b0;
            wb_err       <= 1'b0;
         end
         if (is_wait && (wait_cnt != 32'hFFFF_FFFF)) wait_cnt <= wait_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_writeback_stage_ext.sv
module tb_writeback_stage_ext;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   ResultSrcW;
   logic [127:0] src_bus;
   logic [2:0]   funct3W;
   logic [1:0]   ByteOffW;
   logic         RegWriteW;
   logic [4:0]   RdW;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic [31:0]  ResultW;
   logic [4:0]   RdOutW;
   logic         RegWriteOutW;
   logic         stall;
   logic         wb_err;
   logic [31:0]  wait_cnt;

   // Second instance with NSRC=5 so an out-of-range select is representable.
   logic [2:0]   e_sel;
   logic [159:0] e_bus;
   logic         e_ready, e_stall, e_we, e_err;
   logic [31:0]  e_result, e_wait_cnt;
   logic [4:0]   e_rd;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   writeback_stage_ext dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ResultSrcW(ResultSrcW), .src_bus(src_bus), .funct3W(funct3W),
      .ByteOffW(ByteOffW), .RegWriteW(RegWriteW), .RdW(RdW),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ResultW(ResultW),
      .RdOutW(RdOutW), .RegWriteOutW(RegWriteOutW), .stall(stall),
      .wb_err(wb_err), .wait_cnt(wait_cnt)
   );

   writeback_stage_ext #(.XLEN(32), .NSRC(5), .LOAD_IDX(1)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_ready),
      .ResultSrcW(e_sel), .src_bus(e_bus), .funct3W(funct3W),
      .ByteOffW(ByteOffW), .RegWriteW(RegWriteW), .RdW(RdW),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ResultW(e_result),
      .RdOutW(e_rd), .RegWriteOutW(e_we), .stall(e_stall),
      .wb_err(e_err), .wait_cnt(e_wait_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      ResultSrcW = 2'd0;
      src_bus    = {32'h0000_0C0C, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000};
      funct3W    = 3'b000;
      ByteOffW   = 2'd0;
      RegWriteW  = 1'b0;
      RdW        = 5'd0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      e_sel      = 3'd0;
      e_bus      = {32'hCAFE_0004, 128'h0};
      tick();
      tick();
      check("rst_result", ResultW, 32'h0);
      check("rst_rd", {27'h0, RdOutW}, 32'd0);
      check("rst_we", {31'h0, RegWriteOutW}, 32'd0);
      check("rst_err", {31'h0, wb_err}, 32'd0);
      check("rst_wait_cnt", wait_cnt, 32'd0);
      check("rst_ready", {31'h0, in_ready}, 32'd1);
      check("rst_stall", {31'h0, stall}, 32'd0);
      rst = 1'b0;
      tick();

      // ALU retire
      in_valid = 1'b1; ResultSrcW = 2'd0; src_bus[31:0] = 32'h1234_5678;
      RdW = 5'd5; RegWriteW = 1'b1;
      tick();
      check("alu_result", ResultW, 32'h1234_5678);
      check("alu_rd", {27'h0, RdOutW}, 32'd5);
      check("alu_we", {31'h0, RegWriteOutW}, 32'd1);
      check("alu_err", {31'h0, wb_err}, 32'd0);
      in_valid = 1'b0;
      tick();
      check("idle_we", {31'h0, RegWriteOutW}, 32'd0);
      check("idle_hold", ResultW, 32'h1234_5678);

      // LB off=3 with data in the same cycle
      in_valid = 1'b1; ResultSrcW = 2'd1; funct3W = 3'b000; ByteOffW = 2'd3;
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0011; RdW = 5'd6;
      #1;
      check("lb_no_stall", {31'h0, stall}, 32'd0);
      tick();
      check("lb_result", ResultW, 32'hFFFF_FF80);
      check("lb_we", {31'h0, RegWriteOutW}, 32'd1);
      funct3W = 3'b100;
      tick();
      check("lbu_result", ResultW, 32'h0000_0080);
      funct3W = 3'b001; ByteOffW = 2'd0; mem_rdata = 32'h0000_8001;
      tick();
      check("lh_neg_result", ResultW, 32'hFFFF_8001);
      funct3W = 3'b101;
      tick();
      check("lhu_result", ResultW, 32'h0000_8001);
      funct3W = 3'b000; ByteOffW = 2'd1; mem_rdata = 32'h1234_A57F;
      tick();
      check("lb_off1_result", ResultW, 32'hFFFF_FFA5);

      // LH off=2, data arrives three cycles late
      funct3W = 3'b001; ByteOffW = 2'd2; mem_rvalid = 1'b0;
      mem_rdata = 32'h7FFE_0000; RdW = 5'd7;
      tick();
      check("wait_stall1", {31'h0, stall}, 32'd1);
      check("wait_we", {31'h0, RegWriteOutW}, 32'd0);
      funct3W = 3'b010; ByteOffW = 2'd0; RdW = 5'd30;   // must be ignored in WAIT
      tick();
      check("wait_stall2", {31'h0, stall}, 32'd1);
      tick();
      check("wait_stall3", {31'h0, stall}, 32'd1);
      mem_rvalid = 1'b1;
      tick();
      in_valid = 1'b0; mem_rvalid = 1'b0;
      check("wait_cnt", wait_cnt, 32'd3);
      check("wait_result", ResultW, 32'h0000_7FFE);
      check("wait_rd", {27'h0, RdOutW}, 32'd7);
      check("wait_wr", {31'h0, RegWriteOutW}, 32'd1);
      check("wait_unstall", {31'h0, stall}, 32'd0);

      // Rd=0 suppresses the write
      in_valid = 1'b1; ResultSrcW = 2'd0; src_bus[31:0] = 32'hAAAA_5555;
      RdW = 5'd0; RegWriteW = 1'b1;
      tick();
      check("rd0_we", {31'h0, RegWriteOutW}, 32'd0);
      check("rd0_result", ResultW, 32'hAAAA_5555);

      // Misaligned LW
      ResultSrcW = 2'd1; funct3W = 3'b010; ByteOffW = 2'd2; mem_rvalid = 1'b1;
      mem_rdata = 32'h1122_3344; RdW = 5'd8;
      tick();
      check("lw_mis_err", {31'h0, wb_err}, 32'd1);
      check("lw_mis_result", ResultW, 32'h0);
      check("lw_mis_we", {31'h0, RegWriteOutW}, 32'd0);
      // Bad funct3
      funct3W = 3'b011; ByteOffW = 2'd0;
      tick();
      check("f3_bad_err", {31'h0, wb_err}, 32'd1);
      check("f3_bad_we", {31'h0, RegWriteOutW}, 32'd0);
      // Misaligned LH
      funct3W = 3'b001; ByteOffW = 2'd1;
      tick();
      check("lh_mis_err", {31'h0, wb_err}, 32'd1);
      in_valid = 1'b0; mem_rvalid = 1'b0;
      tick();
      check("err_pulse_end", {31'h0, wb_err}, 32'd0);

      // Out-of-range select on the NSRC=5 instance, then its top valid slot
      in_valid = 1'b1; ResultSrcW = 2'd0; src_bus[31:0] = 32'h0000_0009;
      RdW = 5'd9; e_sel = 3'd5;
      tick();
      check("sel5_err", {31'h0, e_err}, 32'd1);
      check("sel5_result", e_result, 32'h0);
      check("sel5_we", {31'h0, e_we}, 32'd0);
      e_sel = 3'd4;
      tick();
      check("sel4_result", e_result, 32'hCAFE_0004);
      check("sel4_we", {31'h0, e_we}, 32'd1);
      e_sel = 3'd0;

      // Reset while waiting for load data
      ResultSrcW = 2'd1; funct3W = 3'b001; ByteOffW = 2'd0; RdW = 5'd10;
      tick();
      in_valid = 1'b0;
      check("rst_wait_stall", {31'h0, stall}, 32'd1);
      tick();
      rst = 1'b1;
      #1;
      check("rstw_stall", {31'h0, stall}, 32'd0);
      check("rstw_result", ResultW, 32'h0);
      check("rstw_wait_cnt", wait_cnt, 32'd0);
      check("rstw_rd", {27'h0, RdOutW}, 32'd0);
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_5555;
      tick();
      check("rstw_late_we", {31'h0, RegWriteOutW}, 32'd0);
      check("rstw_late_result", ResultW, 32'h0);
      mem_rvalid = 1'b0;

      // PC+4 then a zero-wait load, back to back
      in_valid = 1'b1; ResultSrcW = 2'd2; RdW = 5'd11; RegWriteW = 1'b1;
      tick();
      check("b2b_pc4_result", ResultW, 32'h0000_0104);
      check("b2b_pc4_we", {31'h0, RegWriteOutW}, 32'd1);
      ResultSrcW = 2'd1; funct3W = 3'b010; ByteOffW = 2'd0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5566_7788; RdW = 5'd12;
      #1;
      check("b2b_no_stall", {31'h0, stall}, 32'd0);
      tick();
      check("b2b_lw_result", ResultW, 32'h5566_7788);
      check("b2b_lw_we", {31'h0, RegWriteOutW}, 32'd1);
      check("b2b_lw_rd", {27'h0, RdOutW}, 32'd12);
      in_valid = 1'b0; mem_rvalid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
